// File: rtl/obi_copy_pkg.sv
// Shared types and constants for the OBI word-copy initiator.
package obi_copy_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        FIN
    } copy_state_e;

    localparam int         WORD_BYTES = 4;
    localparam logic [3:0] BE_ALL     = 4'b1111;

endpackage

// File: rtl/obi_copy_master.sv
// Word-granular memory copy initiator on an OBI-style data master port.
// Each word is read, then written, with at most one transaction in flight.
module obi_copy_master
    import obi_copy_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [LEN_WIDTH-1:0]  words_done,
    output logic                  data_req,
    output logic [31:0]           data_addr,
    output logic                  data_we,
    output logic [3:0]            data_be,
    output logic [31:0]           data_wdata,
    output logic [5:0]            data_atop,
    input  logic                  data_gnt,
    input  logic                  data_rvalid,
    input  logic [31:0]           data_rdata
);

    copy_state_e           state;
    logic [ADDR_WIDTH-1:0] cur_src;
    logic [ADDR_WIDTH-1:0] cur_dst;
    logic [ADDR_WIDTH-1:0] src_next;
    logic [ADDR_WIDTH-1:0] dst_next;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  words_next;
    logic                  misaligned;

    // Atomics are never used by a plain copy.
    assign data_atop = '0;

    // Next-word addresses wrap silently at the address width.
    assign src_next   = cur_src + ADDR_WIDTH'(WORD_BYTES);
    assign dst_next   = cur_dst + ADDR_WIDTH'(WORD_BYTES);
    assign words_next = words_done + LEN_WIDTH'(1);
    assign misaligned = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);

    // Copy sequencer: every bus output is registered and set on the transition into its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            words_done <= '0;
            cur_src    <= '0;
            cur_dst    <= '0;
            len_q      <= '0;
            data_req   <= 1'b0;
            data_addr  <= '0;
            data_we    <= 1'b0;
            data_be    <= '0;
            data_wdata <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (misaligned) begin
                            err <= 1'b1;
                        end else if (len == '0) begin
                            state <= FIN;
                            busy  <= 1'b1;
                            done  <= 1'b1;
                        end else begin
                            state      <= RD_REQ;
                            busy       <= 1'b1;
                            cur_src    <= src_addr;
                            cur_dst    <= dst_addr;
                            len_q      <= len;
                            words_done <= '0;
                            data_req   <= 1'b1;
                            data_we    <= 1'b0;
                            data_be    <= BE_ALL;
                            data_addr  <= 32'(src_addr);
                        end
                    end
                end
                RD_REQ: begin
                    if (data_gnt) begin
                        state    <= RD_WAIT;
                        data_req <= 1'b0;
                        data_be  <= '0;
                    end
                end
                RD_WAIT: begin
                    if (data_rvalid) begin
                        state      <= WR_REQ;
                        data_wdata <= data_rdata;
                        data_req   <= 1'b1;
                        data_we    <= 1'b1;
                        data_be    <= BE_ALL;
                        data_addr  <= 32'(cur_dst);
                    end
                end
                WR_REQ: begin
                    if (data_gnt) begin
                        state    <= WR_WAIT;
                        data_req <= 1'b0;
                        data_be  <= '0;
                    end
                end
                WR_WAIT: begin
                    if (data_rvalid) begin
                        words_done <= words_next;
                        cur_src    <= src_next;
                        cur_dst    <= dst_next;
                        if (words_next == len_q) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state     <= RD_REQ;
                            data_req  <= 1'b1;
                            data_we   <= 1'b0;
                            data_be   <= BE_ALL;
                            data_addr <= 32'(src_next);
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_obi_copy_master.sv
// Scoreboard bench for obi_copy_master with a memory-backed OBI responder.
module tb_obi_copy_master;

    localparam int AW = 16;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [LW-1:0] len = '0;
    logic          busy;
    logic          done;
    logic          err;
    logic [LW-1:0] words_done;
    logic          data_req;
    logic [31:0]   data_addr;
    logic          data_we;
    logic [3:0]    data_be;
    logic [31:0]   data_wdata;
    logic [5:0]    data_atop;
    logic          data_gnt = 1'b0;
    logic          data_rvalid = 1'b0;
    logic [31:0]   data_rdata = '0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_txn_t;

    typedef struct {
        logic is_err;
        int   cycle;
        int   words;
    } end_evt_t;

    bus_txn_t    bus_q[$];
    end_evt_t    end_q[$];
    logic [31:0] mem [int unsigned];

    int checks = 0;
    int errors = 0;
    int cycle_count = 0;
    int req_cycles = 0;
    int stall_cycles = 0;
    int wr_grants = 0;
    int late_write = 0;
    bit late_armed = 1'b0;
    bit inject_late = 1'b0;

    obi_copy_master #(
        .ADDR_WIDTH(AW),
        .LEN_WIDTH (LW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .words_done (words_done),
        .data_req   (data_req),
        .data_addr  (data_addr),
        .data_we    (data_we),
        .data_be    (data_be),
        .data_wdata (data_wdata),
        .data_atop  (data_atop),
        .data_gnt   (data_gnt),
        .data_rvalid(data_rvalid),
        .data_rdata (data_rdata)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to time-stamp expected completion pulses.
    always @(posedge clk) cycle_count <= cycle_count + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic flagFail(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    // Unwritten memory returns an address-derived pattern.
    function automatic logic [31:0] memRead(input int unsigned a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory responder: grants after stall_cycles, answers one cycle after grant.
    initial begin : responder
        int          stall_cnt;
        bit          pend;
        logic [31:0] pend_data;
        stall_cnt = 0;
        pend      = 1'b0;
        pend_data = '0;
        forever begin
            @(posedge clk);
            #1;
            data_gnt    = 1'b0;
            data_rvalid = 1'b0;
            if (!rst_n) begin
                stall_cnt = 0;
                pend      = 1'b0;
            end else begin
                if (pend || inject_late) begin
                    data_rvalid = 1'b1;
                    data_rdata  = pend ? pend_data : $urandom;
                    pend        = 1'b0;
                    inject_late = 1'b0;
                end
                if (data_req) begin
                    if (stall_cnt < stall_cycles) begin
                        stall_cnt++;
                    end else begin
                        stall_cnt = 0;
                        data_gnt  = 1'b1;
                        if (data_we) begin
                            mem[data_addr] = data_wdata;
                            wr_grants++;
                            if (wr_grants == late_write) begin
                                late_armed = 1'b1;
                            end else begin
                                pend      = 1'b1;
                                pend_data = $urandom;
                            end
                        end else begin
                            pend      = 1'b1;
                            pend_data = memRead(data_addr);
                        end
                    end
                end
            end
        end
    end

    // Monitor: compares granted requests and completion pulses against the scoreboard queues.
    initial begin : monitor
        logic        prev_req;
        logic        prev_gnt;
        logic        prev_we;
        logic [3:0]  prev_be;
        logic [31:0] prev_addr;
        logic [31:0] prev_wdata;
        bus_txn_t    tx;
        end_evt_t    ev;
        prev_req   = 1'b0;
        prev_gnt   = 1'b0;
        prev_we    = 1'b0;
        prev_be    = '0;
        prev_addr  = '0;
        prev_wdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req = 1'b0;
                prev_gnt = 1'b0;
            end else begin
                if (data_req) req_cycles++;
                if (prev_req && prev_gnt) checkOutput("req_drop_after_gnt", 32'(data_req), 32'd0);
                if (!data_req) checkOutput("be_idle", 32'(data_be), 32'd0);
                if (data_req && prev_req && !prev_gnt) begin
                    checkOutput("hold_addr", data_addr, prev_addr);
                    checkOutput("hold_we", 32'(data_we), 32'(prev_we));
                    checkOutput("hold_be", 32'(data_be), 32'(prev_be));
                    checkOutput("hold_wdata", data_wdata, prev_wdata);
                end
                if (data_req && data_gnt) begin
                    if (bus_q.size() == 0) begin
                        flagFail("unexpected_request", data_addr, 32'd0);
                    end else begin
                        tx = bus_q.pop_front();
                        checkOutput("req_we", 32'(data_we), 32'(tx.we));
                        checkOutput("req_addr", data_addr, tx.addr);
                        checkOutput("req_be", 32'(data_be), 32'hF);
                        checkOutput("req_atop", 32'(data_atop), 32'd0);
                        checkOutput("busy_during_req", 32'(busy), 32'd1);
                        if (tx.we) checkOutput("req_wdata", data_wdata, tx.data);
                    end
                end
                if (done || err) begin
                    if (end_q.size() == 0) begin
                        flagFail("unexpected_end", {30'd0, done, err}, 32'd0);
                    end else begin
                        ev = end_q.pop_front();
                        checkOutput("end_err", 32'(err), 32'(ev.is_err));
                        checkOutput("end_done", 32'(done), 32'(!ev.is_err));
                        checkOutput("end_cycle", 32'(cycle_count), 32'(ev.cycle));
                        checkOutput("busy_at_end", 32'(busy), 32'(!ev.is_err));
                        if (!ev.is_err && ev.words >= 0)
                            checkOutput("words_done", 32'(words_done), 32'(ev.words));
                    end
                end
                prev_req   = data_req;
                prev_gnt   = data_gnt;
                prev_we    = data_we;
                prev_be    = data_be;
                prev_addr  = data_addr;
                prev_wdata = data_wdata;
            end
        end
    end

    // Issue one command and push the reference model's expected traffic and completion.
    task automatic applyStimulus(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                                 input logic [LW-1:0] n, input int stall);
        logic [31:0] pend [int unsigned];
        end_evt_t    ev;
        bus_txn_t    tx;
        int unsigned mask;
        int unsigned sa;
        int unsigned da;
        logic [31:0] d;
        int          t;
        @(negedge clk);
        stall_cycles = stall;
        t    = cycle_count;
        mask = (32'd1 << AW) - 32'd1;
        if (src[1:0] != 2'b00 || dst[1:0] != 2'b00) begin
            ev.is_err = 1'b1;
            ev.cycle  = t + 1;
            ev.words  = -1;
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                sa = (32'(src) + 32'(4 * i)) & mask;
                da = (32'(dst) + 32'(4 * i)) & mask;
                d  = pend.exists(sa) ? pend[sa] : memRead(sa);
                tx.we = 1'b0; tx.addr = sa; tx.data = '0;
                bus_q.push_back(tx);
                tx.we = 1'b1; tx.addr = da; tx.data = d;
                bus_q.push_back(tx);
                pend[da] = d;
            end
            ev.is_err = 1'b0;
            ev.cycle  = t + 1 + int'(n) * (4 + 2 * stall);
            ev.words  = (n == '0) ? -1 : int'(n);
        end
        end_q.push_back(ev);
        start    = 1'b1;
        src_addr = src;
        dst_addr = dst;
        len      = n;
        @(posedge clk);
        #1;
        start    = 1'b0;
        src_addr = AW'($urandom);
        dst_addr = AW'($urandom);
        len      = LW'($urandom);
    endtask

    // Wait, bounded, until all expected traffic and pulses have been consumed.
    task automatic waitQuiet(input int budget);
        int n;
        n = 0;
        while ((end_q.size() != 0 || bus_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (end_q.size() != 0 || bus_q.size() != 0) begin
            flagFail("timeout_pending", 32'(end_q.size() + bus_q.size()), 32'd0);
            end_q.delete();
            bus_q.delete();
        end
        repeat (2) @(negedge clk);
        checkOutput("busy_after_end", 32'(busy), 32'd0);
    endtask

    task automatic checkResetValues();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_req", 32'(data_req), 32'd0);
        checkOutput("rst_we", 32'(data_we), 32'd0);
        checkOutput("rst_words", 32'(words_done), 32'd0);
        checkOutput("rst_addr", data_addr, 32'd0);
        checkOutput("rst_wdata", data_wdata, 32'd0);
        checkOutput("rst_be", 32'(data_be), 32'd0);
        checkOutput("rst_atop", 32'(data_atop), 32'd0);
    endtask

    // Directed scenarios followed by randomized copies.
    initial begin : stimulus
        int          r0;
        int          guard;
        logic [AW-1:0] s;
        logic [AW-1:0] d;
        logic [LW-1:0] n;
        int          st;

        #2;
        checkResetValues();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] basic copy");
        for (int i = 0; i < 4; i++) mem[32'h100 + 32'(4 * i)] = 32'h1111_1111 * 32'(i + 1);
        applyStimulus(16'h0100, 16'h0200, 16'd4, 0);
        waitQuiet(100);
        for (int i = 0; i < 4; i++)
            checkOutput("basic_mem", memRead(32'h200 + 32'(4 * i)), 32'h1111_1111 * 32'(i + 1));

        $display("[TB] stalled grants");
        applyStimulus(16'h0100, 16'h0280, 16'd4, 3);
        waitQuiet(200);
        stall_cycles = 0;

        $display("[TB] rejected and empty commands");
        r0 = req_cycles;
        applyStimulus(16'h0102, 16'h0200, 16'd4, 0);
        waitQuiet(20);
        checkOutput("misaligned_src_no_req", 32'(req_cycles - r0), 32'd0);
        r0 = req_cycles;
        applyStimulus(16'h0100, 16'h0203, 16'd4, 0);
        waitQuiet(20);
        checkOutput("misaligned_dst_no_req", 32'(req_cycles - r0), 32'd0);
        r0 = req_cycles;
        applyStimulus(16'h0100, 16'h0200, 16'd0, 0);
        waitQuiet(20);
        checkOutput("zero_len_no_req", 32'(req_cycles - r0), 32'd0);

        $display("[TB] start while busy");
        applyStimulus(16'h0100, 16'h0800, 16'd8, 0);
        repeat (6) @(negedge clk);
        start = 1'b1; src_addr = 16'h0040; dst_addr = 16'h0900; len = 16'd3;
        @(negedge clk);
        start = 1'b0;
        waitQuiet(200);

        $display("[TB] address wrap");
        applyStimulus(16'hFFF8, 16'h0400, 16'd4, 0);
        waitQuiet(100);

        $display("[TB] reset mid-copy");
        late_armed = 1'b0;
        late_write = wr_grants + 2;
        applyStimulus(16'h0300, 16'h0500, 16'd4, 0);
        guard = 0;
        while (!late_armed && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!late_armed) flagFail("late_write_timeout", 32'(guard), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #2;
        checkResetValues();
        repeat (2) @(negedge clk);
        bus_q.delete();
        end_q.delete();
        late_write = 0;
        late_armed = 1'b0;
        rst_n = 1'b1;
        inject_late = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("post_reset_busy", 32'(busy), 32'd0);
        checkOutput("post_reset_req", 32'(data_req), 32'd0);
        checkOutput("post_reset_words", 32'(words_done), 32'd0);
        applyStimulus(16'h0300, 16'h0600, 16'd3, 1);
        waitQuiet(200);

        $display("[TB] randomized copies");
        for (int k = 0; k < 8; k++) begin
            s  = AW'({$urandom_range(0, 16'h3FFF), 2'b00});
            d  = AW'({$urandom_range(0, 16'h3FFF), 2'b00});
            n  = LW'($urandom_range(1, 6));
            st = $urandom_range(0, 2);
            for (int i = 0; i < int'(n); i++) mem[32'(AW'(s + AW'(4 * i)))] = $urandom;
            if ($urandom_range(0, 5) == 0) s[0] = 1'b1;
            if ($urandom_range(0, 5) == 0) d[1] = 1'b1;
            if ($urandom_range(0, 5) == 0) d = s + AW'(4);
            applyStimulus(s, d, n, st);
            waitQuiet(300);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
